// File: rtl/pc_unit_if.sv
// Control/address bundle between the control unit and pc_unit.
// master = control side (drives redirects), slave = pc_unit.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, call, ret,
        input  pc, pc_plus, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, call, ret,
        output pc, pc_plus, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/return next-pc selection.
// Define PC_UNIT_RAS_EN to compile in the circular return-address stack.
module pc_unit #(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic    clk,
    input  logic    rst,
    pc_unit_if.slave bus
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] pc_next;

    assign pc_plus     = pc_q + WIDTH'(STEP);
    assign bus.pc      = pc_q;
    assign bus.pc_plus = pc_plus;

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;   // next free slot; top of stack is wr_ptr-1
    logic [CNT_W-1:0] count;
    logic             overflow_q;
    logic             underflow_q;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             do_push;
    logic [WIDTH-1:0] ras_top;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(RAS_DEPTH));
    assign ras_top  = stack[wr_ptr - PTR_W'(1)];

    // A return always beats a simultaneous call: the pop happens, the push is dropped.
    assign do_pop  = !bus.stall && bus.ret && !is_empty;
    assign do_push = !bus.stall && bus.jump && bus.call && !do_pop;

    always_comb begin
        // NOTE: default first so every path assigns pc_next and no latch is inferred.
        pc_next = pc_q;
        if (!bus.stall) begin
            if (do_pop)                pc_next = ras_top;
            else if (bus.jump)         pc_next = bus.jump_target;
            else if (bus.branch_taken) pc_next = bus.branch_target;
            else                       pc_next = pc_plus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            wr_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            overflow_q  <= do_push && is_full;
            underflow_q <= !bus.stall && bus.ret && is_empty;
            if (do_pop) begin
                wr_ptr <= wr_ptr - PTR_W'(1);
                count  <= count - CNT_W'(1);
            end else if (do_push) begin
                // Circular: on full the pointer still advances over the oldest entry.
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!is_full) count <= count + CNT_W'(1);
            end
        end
    end

    // NOTE: stack storage is not reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) stack[wr_ptr] <= pc_plus;
    end

    assign bus.ras_empty     = is_empty;
    assign bus.ras_full      = is_full;
    assign bus.ras_overflow  = overflow_q;
    assign bus.ras_underflow = underflow_q;
`else
    logic unused_ras_ctl;
    assign unused_ras_ctl = ^{bus.call, bus.ret, (RAS_DEPTH > 1)};

    always_comb begin
        pc_next = pc_q;
        if (!bus.stall) begin
            if (bus.jump)              pc_next = bus.jump_target;
            else if (bus.branch_taken) pc_next = bus.branch_target;
            else                       pc_next = pc_plus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_next;
    end

    assign bus.ras_empty     = 1'b1;
    assign bus.ras_full      = 1'b0;
    assign bus.ras_overflow  = 1'b0;
    assign bus.ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pc_unit;
    localparam int unsigned W     = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(W)) bus ();

    pc_unit #(
        .WIDTH(W), .STEP(STEP), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pc value plus a queue of return addresses (newest at back).
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit br, input logic [31:0] bt,
                              input bit j, input logic [31:0] jt, input bit c, input bit r);
        logic [31:0] seq;
        bit pop, push;
        if (st) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            seq   = m_pc + STEP;
            pop   = RAS_EN && r && (m_ras.size() != 0);
            m_unf = RAS_EN && r && (m_ras.size() == 0);
            push  = RAS_EN && j && c && !pop;
            m_ovf = push && (m_ras.size() == DEPTH);
            if (pop)     m_pc = m_ras.pop_back();
            else if (j)  m_pc = jt;
            else if (br) m_pc = bt;
            else         m_pc = seq;
            if (push) begin
                m_ras.push_back(seq);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/pc"},        bus.pc, m_pc);
        check({tag, "/pc_plus"},   bus.pc_plus, m_pc + STEP);
        check({tag, "/empty"},     32'(bus.ras_empty), 32'(!RAS_EN || m_ras.size() == 0));
        check({tag, "/full"},      32'(bus.ras_full), 32'(RAS_EN && m_ras.size() == DEPTH));
        check({tag, "/overflow"},  32'(bus.ras_overflow), 32'(m_ovf));
        check({tag, "/underflow"}, 32'(bus.ras_underflow), 32'(m_unf));
    endtask

    task automatic cyc(input string tag, input bit st, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit c, input bit r);
        bus.stall = st; bus.branch_taken = br; bus.branch_target = bt;
        bus.jump = j; bus.jump_target = jt; bus.call = c; bus.ret = r;
        @(posedge clk);
        model_step(st, br, bt, j, jt, c, r);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic jmp(input string tag, input logic [31:0] t, input bit c);
        cyc(tag, 0, 0, '0, 1, t, c, 0);
    endtask

    task automatic do_ret(input string tag);
        cyc(tag, 0, 0, '0, 0, '0, 0, 1);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, "/pc_now"}, bus.pc, RV);
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.jump = 0; bus.jump_target = '0; bus.call = 0; bus.ret = 0;
        rst = 1'b1;
        model_reset();
        #12;
        check("reset/pc", bus.pc, 32'h100);
        check_all("reset");
        rst = 1'b0;

        // Reset and run
        idle("run1"); check("run1/abs", bus.pc, 32'h104);
        idle("run2"); check("run2/abs", bus.pc, 32'h108);
        idle("run3"); check("run3/abs", bus.pc, 32'h10C);
        async_reset("midrst");

        // Priority
        jmp("pri_set", 32'h200, 0);
        cyc("pri_both", 0, 1, 32'h300, 1, 32'h400, 0, 0);
        check("pri_both/abs", bus.pc, 32'h400);
        jmp("pri_set2", 32'h200, 0);
        cyc("pri_br", 0, 1, 32'h300, 0, '0, 0, 0);
        check("pri_br/abs", bus.pc, 32'h300);
        jmp("pri_set3", 32'h200, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 1, 1, 32'h300, 1, 32'h400, 1, 1);
            check("stall/abs", bus.pc, 32'h200);
        end

        // Call/return
        jmp("cr_set", 32'h500, 0);
        jmp("cr_call", 32'h800, 1);
        check("cr_call/abs", bus.pc, 32'h800);
        do_ret("cr_ret");
`ifdef PC_UNIT_RAS_EN
        check("cr_ret/abs", bus.pc, 32'h504);
`else
        check("cr_ret/abs", bus.pc, 32'h804);
`endif
        check("cr_ret/empty", 32'(bus.ras_empty), 32'd1);

        // Overflow
        for (int k = 1; k <= 5; k++) begin
            jmp("ov_set", 32'(k * 16), 0);
            jmp("ov_call", 32'h1000 + 32'(k * 256), 1);
`ifdef PC_UNIT_RAS_EN
            if (k == 4) check("ov_full4", 32'(bus.ras_full), 32'd1);
            if (k == 5) check("ov_pulse", 32'(bus.ras_overflow), 32'd1);
`endif
        end
        do_ret("ov_ret1");
`ifdef PC_UNIT_RAS_EN
        check("ov_ret1/abs", bus.pc, 32'h54);
        check("ov_pulse_end", 32'(bus.ras_overflow), 32'd0);
`endif
        do_ret("ov_ret2");
        do_ret("ov_ret3");
        do_ret("ov_ret4");
`ifdef PC_UNIT_RAS_EN
        check("ov_ret4/abs", bus.pc, 32'h24);
`endif
        check("ov_empty", 32'(bus.ras_empty), 32'd1);

        // Underflow and wrap
        jmp("un_set", 32'h600, 0);
        do_ret("un_ret");
        check("un_ret/abs", bus.pc, 32'h604);
        check("un_pulse", 32'(bus.ras_underflow), 32'(RAS_EN));
        idle("un_after");
        jmp("wrap_set", 32'hFFFF_FFFC, 0);
        idle("wrap");
        check("wrap/abs", bus.pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom();
            jt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom();
            cyc("rand",
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, bt,
                $urandom_range(0, 2) == 0, jt,
                $urandom_range(0, 1) == 0,
                $urandom_range(0, 3) == 0);
            if (i % 150 == 149) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle datapath, replacing the plain `pcNext` → `pc` register. It holds the current instruction address and computes the next one from four sources: sequential increment, branch target, jump target and a small return-address stack (RAS). It also supports stall and an asynchronous reset to a configurable vector. It feeds instruction memory and the branch/jump adders, and takes its redirect controls from the control unit.

## Interface
- `WIDTH`, 32, address width in bits
- `STEP`, 4, sequential increment in bytes
- `RESET_VECTOR`, 0, value loaded into `pc` on reset
- `RAS_DEPTH`, 4, return-address stack entries (≥2, power of two)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold `pc` and RAS this cycle
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  WIDTH  branch destination
- `jump`  in  1  redirect to `jump_target`
- `jump_target`  in  WIDTH  jump destination
- `call`  in  1  with `jump`: push `pc_plus` onto the RAS
- `ret`  in  1  redirect to the RAS top and pop
- `pc`  out  WIDTH  current address (registered)
- `pc_plus`  out  WIDTH  `pc + STEP`, combinational
- `ras_empty`  out  1  RAS holds 0 entries
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries
- `ras_overflow`  out  1  one-cycle pulse: push while full
- `ras_underflow`  out  1  one-cycle pulse: `ret` while empty

## Operation
- **Reset.** While `rst`=1: `pc`=RESET_VECTOR, RAS count=0, `ras_empty`=1, `ras_full`=0, both pulse flags 0. The stack contents need not be cleared.
- **Next-pc selection**, evaluated when `stall`=0, highest priority first:
  - `ret` with RAS non-empty → RAS top, and pop.
  - `jump` → `jump_target`. If `call`=1, also push `pc_plus`.
  - `branch_taken` → `branch_target`.
  - Otherwise → `pc_plus`.
- **Stall.** `stall`=1: `pc`, RAS contents, count and pulse flags are all held at their previous state, except that both pulses go to 0. All other inputs are ignored.
- **`ret` on empty RAS.** Treated as if `ret`=0: selection falls through to jump, branch or sequential. `ras_underflow` pulses. Count stays 0.
- **`ret` together with `jump`+`call`.** `ret` wins. The pop happens, the push is dropped, and no overflow is flagged.
- **`call` without `jump`.** Ignored.
- **Push on full.** The stack is circular. The oldest entry is overwritten, the count stays `RAS_DEPTH`, and `ras_overflow` pulses. A later pop sequence returns the newest `RAS_DEPTH` addresses in LIFO order.
- **Arithmetic.** `pc_plus` is computed modulo 2^WIDTH, so `pc`=2^WIDTH−STEP wraps to 0. Targets are used verbatim, with no alignment checks.
- **State.** Stack pointer plus count (0..RAS_DEPTH). No other FSM.

## Timing
- `pc` updates on the rising `clk` edge. A redirect presented in cycle N appears on `pc` in cycle N+1 (one-cycle latency).
- `pc_plus` and the RAS top read are combinational from current state.
- `ras_empty`/`ras_full` reflect the registered count.
- Pulse flags are registered: high for exactly the cycle after the offending edge.
- Deasserting `rst` takes effect asynchronously. The first update happens on the first rising edge after release: `pc` goes RESET_VECTOR → RESET_VECTOR+STEP, absent redirects.
- Asserting `rst` mid-operation forces reset values immediately, regardless of `clk`, and discards pending pushes/pops.

## Configuration
- `PC_UNIT_RAS_EN` defined:
  - RAS storage and pointer logic are compiled in.
  - `call`, `ret`, `ras_*` behave as above.
- `PC_UNIT_RAS_EN` undefined:
  - No RAS storage exists.
  - `call` and `ret` are ignored, so selection is jump > branch > sequential.
  - `ras_empty`=1, `ras_full`=0, `ras_overflow`=0, `ras_underflow`=0 constantly.
  - The port list is unchanged.

## Test plan
Parameters for all scenarios: WIDTH=32, STEP=4, RESET_VECTOR=0x100, RAS_DEPTH=4.
- **Reset and run.** `rst`=1, then release with no controls for 3 edges → `pc` = 0x100, 0x104, 0x108, 0x10C. Reasserting `rst` mid-cycle → `pc`=0x100 immediately.
- **Priority.** At `pc`=0x200, drive `branch_taken`=1/0x300 and `jump`=1/0x400 together → next `pc`=0x400. Branch alone → 0x300. With `stall`=1 and both asserted → `pc` holds 0x200 for every stalled cycle.
- **Call/return.** At `pc`=0x500, `jump`+`call` to 0x800 → `pc`=0x800. Then `ret` → `pc`=0x504 and `ras_empty`=1.
- **Overflow.** Five `jump`+`call` from 0x10, 0x20, 0x30, 0x40, 0x50 (targets chosen arbitrarily):
  - `ras_full`=1 after the 4th push.
  - The 5th push pulses `ras_overflow` for 1 cycle.
  - Four `ret`s then yield 0x54, 0x44, 0x34, 0x24.
  - `ras_empty`=1 at the end.
- **Underflow and wrap.**
  - `ret` on empty at `pc`=0x600 → `pc`=0x604 and `ras_underflow` pulses once.
  - Jump to 0xFFFFFFFC, then one sequential step → `pc`=0x00000000.
- **Build without `PC_UNIT_RAS_EN`.** Repeat the call/return scenario → `ret` is ignored and `pc`=0x804 after the `ret` cycle. `ras_empty` stays 1 throughout.
